// File: rtl/p_shfrot_mc.sv
// p_shfrot_mc: multi-cycle packed shift/rotate unit.
// A request loads the operand into a working register. The unit then applies
// one 1-bit step per cycle to every W-bit element independently, until the
// step count is used up. The result is held in DONE until the consumer takes
// it or the operation is flushed.
module p_shfrot_mc (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] crs1,
   input  logic [4:0]  shamt,
   input  logic [4:0]  pw,
   input  logic        shift,
   input  logic        rotate,
   input  logic        left,
   input  logic        right,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // True when exactly one bit of the pack-width select is set.
   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

   // Index of the top bit inside an element (W-1) for a one-hot width select.
   function automatic logic [4:0] elem_msb_idx(input logic [4:0] p);
      logic [4:0] r;
      case (p)
         5'b00001: r = 5'd31;
         5'b00010: r = 5'd15;
         5'b00100: r = 5'd7;
         5'b01000: r = 5'd3;
         5'b10000: r = 5'd1;
         default:  r = 5'd0;
      endcase
      return r;
   endfunction

   // Mask with a 1 at the lowest bit of every element.
   function automatic logic [31:0] mask_lo(input logic [4:0] p);
      logic [31:0] r;
      case (p)
         5'b00001: r = 32'h0000_0001;
         5'b00010: r = 32'h0001_0001;
         5'b00100: r = 32'h0101_0101;
         5'b01000: r = 32'h1111_1111;
         5'b10000: r = 32'h5555_5555;
         default:  r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Mask with a 1 at the highest bit of every element.
   function automatic logic [31:0] mask_hi(input logic [4:0] p);
      logic [31:0] r;
      case (p)
         5'b00001: r = 32'h8000_0000;
         5'b00010: r = 32'h8000_8000;
         5'b00100: r = 32'h8080_8080;
         5'b01000: r = 32'h8888_8888;
         5'b10000: r = 32'haaaa_aaaa;
         default:  r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // One 1-bit step on every element. The whole-word shift is masked at the
   // element boundaries so no bit leaks into a neighbour; a rotate then puts
   // the element's outgoing end bit back at the opposite end.
   function automatic logic [31:0] step1(input logic [31:0] w, input logic [4:0] p,
                                         input logic rot, input logic lft);
      logic [31:0] sh;
      logic [31:0] fill;
      logic [4:0]  msb;
      msb = elem_msb_idx(p);
      if (lft) begin
         sh   = (w << 1) & ~mask_lo(p);
         fill = (w & mask_hi(p)) >> msb;
      end else begin
         sh   = (w >> 1) & ~mask_hi(p);
         fill = (w & mask_lo(p)) << msb;
      end
      return rot ? (sh | fill) : sh;
   endfunction

   // Number of steps: shifts saturate at the element width, rotates wrap.
   // A shift of W only needs 5 bits because shamt never exceeds 31.
   function automatic logic [4:0] step_count(input logic [4:0] amt, input logic [4:0] p,
                                             input logic rot);
      logic [4:0] msb;
      logic [4:0] r;
      msb = elem_msb_idx(p);
      if (rot) begin
         r = amt & msb;
      end else if (amt > msb) begin
         r = msb + 5'd1;
      end else begin
         r = amt;
      end
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  pw_q, pw_d;
   logic        rot_q, rot_d;
   logic        left_q, left_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] result_q, result_d;

   logic        legal_s;
   logic [4:0]  count_s;

   // Request decode: an illegal control combination yields zero steps and a zero result.
   always_comb begin
      legal_s = is_onehot5(pw) && (shift != rotate) && (left != right);
      if (legal_s) begin
         count_s = step_count(shamt, pw, rotate);
      end else begin
         count_s = 5'd0;
      end
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      pw_d    = pw_q;
      rot_d   = rot_q;
      left_d  = left_q;
      case (state_q)
         ST_IDLE: begin
            // Flush has no effect here; a request is taken normally.
            if (in_valid && in_ready_q) begin
               work_d = legal_s ? crs1 : 32'h0000_0000;
               pw_d   = pw;
               rot_d  = rotate;
               left_d = left;
               cnt_d  = count_s;
               if (count_s == 5'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
               work_d  = 32'h0000_0000;
            end else begin
               work_d = step1(work_q, pw_q, rot_q, left_q);
               cnt_d  = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            // Flush wins over out_ready; both leave DONE.
            if (flush || out_ready) begin
               state_d = ST_IDLE;
               work_d  = 32'h0000_0000;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            work_d  = 32'h0000_0000;
         end
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      result_d    = (state_d == ST_DONE) ? work_d : 32'h0000_0000;
   end

   // State, datapath and output registers; reset clears everything at once.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         work_q      <= 32'h0000_0000;
         pw_q        <= 5'd0;
         rot_q       <= 1'b0;
         left_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         pw_q        <= pw_d;
         rot_q       <= rot_d;
         left_q      <= left_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_p_shfrot_mc.sv
// Directed bench for p_shfrot_mc: vectors with hand-computed results and latencies.
module tb_p_shfrot_mc;

   logic        clock = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] crs1;
   logic [4:0]  shamt;
   logic [4:0]  pw;
   logic        shift, rotate, left, right;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   p_shfrot_mc dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .crs1(crs1), .shamt(shamt), .pw(pw), .shift(shift), .rotate(rotate),
      .left(left), .right(right), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [4:0]  sa;
      logic [4:0]  p;
      logic        sh, ro, le, ri;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   // Present a request; returns just after the accepting edge with inputs scrambled.
   task automatic start_op(input logic [31:0] a, input logic [4:0] sa, input logic [4:0] p,
                           input logic sh, input logic ro, input logic le, input logic ri);
      @(negedge clock);
      crs1 = a; shamt = sa; pw = p; shift = sh; rotate = ro; left = le; right = ri;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      crs1 = $urandom; shamt = 5'($urandom); pw = 5'($urandom);
      shift = 1'($urandom); rotate = 1'($urandom); left = 1'($urandom); right = 1'($urandom);
   endtask

   // Count edges after acceptance until out_valid rises (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic complete_op();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", result); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      repeat (2) @(posedge clock);
      @(negedge clock); resetn = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
      @(posedge clock); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_vectors();
      vec_t v[13];
      int lat;
      v[0]  = '{32'h8000_0001, 5'd1,  5'b00001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 1};
      v[1]  = '{32'h8000_8000, 5'd3,  5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_1000, 3};
      v[2]  = '{32'hFFFF_FFFF, 5'd9,  5'b00100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 8};
      v[3]  = '{32'h0000_0001, 5'd3,  5'b10000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1};
      v[4]  = '{32'h1234_5678, 5'd0,  5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 0};
      v[5]  = '{32'h1234_5678, 5'd1,  5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2468_ACE1, 1};
      v[6]  = '{32'h0102_0304, 5'd2,  5'b00100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4080_C001, 2};
      v[7]  = '{32'h8000_0000, 5'd31, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 31};
      v[8]  = '{32'hFFFF_FFFF, 5'd5,  5'b10000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2};
      v[9]  = '{32'h8000_0001, 5'd17, 5'b00010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_0002, 1};
      v[10] = '{32'hFFFF_FFFF, 5'd5,  5'b00011, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 0};
      v[11] = '{32'h0000_000F, 5'd3,  5'b00001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 0};
      v[12] = '{32'h0000_000F, 5'd3,  5'b00001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 0};
      for (int i = 0; i < 13; i++) begin
         start_op(v[i].a, v[i].sa, v[i].p, v[i].sh, v[i].ro, v[i].le, v[i].ri);
         if (v[i].lat > 0) begin
            total++; if (result !== 32'h0) begin bad++; $display("FAIL vec%0d_run_result got=%h exp=00000000", i, result); end
         end
         wait_done(lat);
         total++; if (lat != v[i].lat) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
         total++; if (result !== v[i].exp) begin bad++; $display("FAIL vec%0d_result got=%h exp=%h", i, result, v[i].exp); end
         complete_op();
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_release got=%b%b exp=01", i, out_valid, in_ready); end
      end
   endtask

   task automatic test_hold();
      int lat;
      start_op(32'h0000_000F, 5'd4, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_done(lat);
      total++; if (lat != 4) begin bad++; $display("FAIL hold_latency got=%0d exp=4", lat); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0000_00F0) begin
            bad++; $display("FAIL hold_cycle%0d got=%b%b %h exp=10 000000f0", k, out_valid, in_ready, result);
         end
      end
      complete_op();
      total++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL hold_release got=%b %h %b exp=0 00000000 1", out_valid, result, in_ready);
      end
   endtask

   task automatic test_flush();
      int lat;
      int seen;
      start_op(32'h0000_0001, 5'd5, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0);
      @(posedge clock); #1;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         bad++; $display("FAIL flush_run got=%b%b %h exp=01 00000000", out_valid, in_ready, result);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
      // Flush in DONE drops the held result.
      start_op(32'h0000_0001, 5'd1, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_done(lat);
      total++; if (result !== 32'h0000_0002) begin bad++; $display("FAIL flush_done_pre got=%h exp=00000002", result); end
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      total++; if (out_valid !== 1'b0 || result !== 32'h0) begin bad++; $display("FAIL flush_done got=%b %h exp=0 00000000", out_valid, result); end
      // Flush in IDLE is ignored and a simultaneous request is taken.
      flush = 1'b1;
      start_op(32'h8000_0001, 5'd1, 5'b00001, 1'b0, 1'b1, 1'b1, 1'b0);
      flush = 1'b0;
      wait_done(lat);
      total++; if (lat != 1 || result !== 32'h0000_0003) begin bad++; $display("FAIL flush_idle got=%0d %h exp=1 00000003", lat, result); end
      complete_op();
   endtask

   task automatic test_reset_mid_run();
      int seen;
      start_op(32'hFFFF_FFFF, 5'd8, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) begin @(posedge clock); #1; end
      resetn = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL reset_run got=%b %h %b exp=0 00000000 0", out_valid, result, in_ready);
      end
      @(negedge clock); resetn = 1'b1;
      @(posedge clock); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_run_ready got=%b exp=1", in_ready); end
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL reset_run_no_valid got=%0d exp=0", seen); end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      crs1 = 32'h0; shamt = 5'd0; pw = 5'd0;
      shift = 1'b0; rotate = 1'b0; left = 1'b0; right = 1'b0;
      test_reset();
      test_vectors();
      test_hold();
      test_flush();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/p_shfrot_mc.md
P_SHFROT_MC -- requirements
Module: p_shfrot_mc

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  operation request.
REQ-004 SHALL have ports: in_ready  out  1  unit can accept a request.
REQ-005 SHALL have ports: crs1  in  32  source operand.
REQ-006 SHALL have ports: shamt  in  5  shift/rotate amount.
REQ-007 SHALL have ports: pw  in  5  pack width select: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
REQ-008 SHALL have ports: shift, rotate, left, right  in  1 each  operation select.
REQ-009 SHALL have ports: flush  in  1  abandon the in-flight operation.
REQ-010 SHALL have ports: out_valid  out  1  result available.
REQ-011 SHALL have ports: out_ready  in  1  consumer takes the result.
REQ-012 SHALL have ports: result  out  32  operation result.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept a request on an edge where in_valid&in_ready, registering crs1 into a working register and all controls.
REQ-015 SHALL apply each step as a 1-bit shift/rotate of every W-bit element independently; no bit crosses an element boundary.
REQ-016 SHALL fill vacated bits with 0 for shifts, and move the element's end bit into the opposite end for rotates.
REQ-017 SHALL set step count: shift = min(shamt, W); rotate = shamt mod W.
REQ-018 SHALL go IDLE->DONE on accept when count=0 (result=crs1), else IDLE->RUN with counter=count.
REQ-019 SHALL perform one step per RUN edge and decrement the counter; the edge with counter=1 moves to DONE.
REQ-020 SHALL raise out_valid after accept edge N+count (N+0 for count=0).
REQ-021 SHALL hold result and out_valid stable in DONE until out_ready=1; that edge returns to IDLE.
REQ-022 SHALL NOT accept a request on the same edge as out_ready completion; next accept is earliest one cycle later.
REQ-023 SHALL treat pw not exactly one-hot, shift==rotate, or left==right as illegal: count=0, result=0x00000000.
REQ-024 SHALL, on flush=1 in RUN or DONE, go to IDLE on the next edge, drop out_valid, and discard the result; flush SHALL take priority over out_ready.
REQ-025 SHALL ignore flush in IDLE, including a simultaneous in_valid, which is accepted normally.
REQ-026 SHALL ignore input changes after acceptance until the next accept.
REQ-027 SHALL drive result=0 whenever not in DONE.

Reset
REQ-028 SHALL, on resetn=0, immediately force state=IDLE, counter=0, working register=0, out_valid=0, result=0.
REQ-029 SHALL set in_ready=1 one cycle after resetn deasserts.
REQ-030 SHALL, on reset mid-RUN or mid-DONE, lose the operation and produce no out_valid for it after release.
REQ-031 SHALL synchronise the resetn deassertion externally; the block does not synchronise it.

Verification
REQ-032 SHALL verify: pw=00001, rotate left, shamt=1, crs1=0x80000001 -> result 0x00000003, out_valid after N+1.
REQ-033 SHALL verify: pw=00010, shift right, shamt=3, crs1=0x80008000 -> result 0x10001000, out_valid after N+3.
REQ-034 SHALL verify: pw=00100, shift left, shamt=9, crs1=0xFFFFFFFF -> count clamps to 8, result 0x00000000, out_valid after N+8.
REQ-035 SHALL verify: pw=10000, rotate right, shamt=3, crs1=0x00000001 -> effective 1, result 0x00000002; a second case, pw=01000, rotate left, shamt=0, crs1=0x12345678 -> result 0x12345678, out_valid after N+0.
REQ-036 SHALL verify: DONE with out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-037 SHALL verify: flush at cycle 2 of a 5-step op -> IDLE next edge, no out_valid; resetn=0 mid-RUN -> outputs 0 immediately; pw=00011 -> result 0, out_valid after N+0.
